// File: rtl/im_arbiter.sv
// im_arbiter: shares the single IM BRAM port between IF fetch and loader.
// Loader/LOAD phase is built only when IM_LOADER_EN is defined.
package im_pkg;
  typedef logic [11:0] im_addr_t;
  typedef logic [31:0] inst_t;
endpackage

module im_arbiter
  import im_pkg::*;
#(
  parameter int STARVE_MAX = 15
) (
  input  logic     cpu_clk_50M,
  input  logic     cpu_rst_n,
  input  logic     if_req,
  input  im_addr_t if_addr,
  output logic     if_stall,
  output logic     if_rvalid,
  input  logic     ld_valid,
  input  im_addr_t ld_addr,
  input  inst_t    ld_data,
  output logic     ld_ready,
  input  logic     ld_done,
  input  logic     ld_start,
  output logic     load_busy,
  output im_addr_t imaddr,
  output logic     imwe,
  output inst_t    imdin,
  output logic     imce
);

  logic rd_fire;

`ifdef IM_LOADER_EN

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          forced;
  logic          wr_force;
  logic          rd_go;
  logic          wr_idle;

  // A pending write denied STARVE_MAX times wins the next slot.
  assign forced   = ld_valid && (starve_q == SMAX);
  assign wr_force = forced;
  assign rd_go    = if_req && !forced;
  assign wr_idle  = !if_req && ld_valid && !forced;

  assign load_busy = (state_q == ST_LOAD);

  // Phase and starvation counter registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= ST_LOAD;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Port arbitration, next phase and next starvation count.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    imce     = 1'b0;
    imwe     = 1'b0;
    imaddr   = if_addr;
    imdin    = ld_data;
    if_stall = 1'b1;
    ld_ready = 1'b0;
    rd_fire  = 1'b0;
    if (!cpu_rst_n) begin
      imce   = 1'b1;
      imaddr = '0;
      imdin  = '0;
    end else if (state_q == ST_LOAD) begin
      ld_ready = 1'b1;
      starve_d = '0;
      if (ld_valid) begin
        imce   = 1'b1;
        imwe   = 1'b1;
        imaddr = ld_addr;
      end
      if (ld_done) begin
        state_d = ST_RUN;
      end
    end else begin
      if_stall = 1'b0;
      unique case (1'b1)
        wr_force: begin
          ld_ready = 1'b1;
          if_stall = if_req;
          imce     = 1'b1;
          imwe     = 1'b1;
          imaddr   = ld_addr;
        end
        rd_go: begin
          imce    = 1'b1;
          rd_fire = 1'b1;
        end
        wr_idle: begin
          ld_ready = 1'b1;
          imce     = 1'b1;
          imwe     = 1'b1;
          imaddr   = ld_addr;
        end
        default: begin
        end
      endcase
      if (!ld_valid || ld_ready) begin
        starve_d = '0;
      end else if (starve_q != SMAX) begin
        starve_d = starve_q + 1'b1;
      end
      if (ld_start) begin
        state_d = ST_LOAD;
      end
    end
  end

`else

  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_addr, ld_data, ld_done, ld_start};

  localparam int unused_starve = STARVE_MAX;

  assign load_busy = 1'b0;

  // Fetch owns the port; reset keeps the BRAM output clear enabled.
  always_comb begin
    imce     = if_req;
    imwe     = 1'b0;
    imaddr   = if_addr;
    imdin    = '0;
    if_stall = 1'b0;
    ld_ready = 1'b0;
    rd_fire  = if_req;
    if (!cpu_rst_n) begin
      imce    = 1'b1;
      imaddr  = '0;
      rd_fire = 1'b0;
    end
  end

`endif

  // Read data shows up one cycle after the fetch is served.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      if_rvalid <= 1'b0;
    end else begin
      if_rvalid <= rd_fire;
    end
  end

endmodule

// File: doc/im_arbiter.md
# im_arbiter

Owns the single port of the instruction-memory BRAM and shares it between the CPU fetch stage (read-only) and the boot/debug loader (write-only). After reset it holds the CPU in a LOAD phase in which the loader fills the IM. It then switches to RUN, where fetch has priority and loader writes use idle slots, bounded by a starvation counter. It sits between the IF stage / loader and the `im` instance, on the same clock.

## Interface
Parameters:
- STARVE_MAX, 15: maximum consecutive cycles a pending loader write may be denied in RUN before it is forced through; legal range 1..255.

Ports:
- cpu_clk_50M  in  1  system clock, all state on rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch requests a read this cycle.
- if_addr  in  im_addr_t  word address of the fetch.
- if_stall  out  1  fetch not served this cycle; IF must hold PC.
- if_rvalid  out  1  `inst` carries data for the fetch accepted last cycle.
- ld_valid  in  1  loader write request.
- ld_addr  in  im_addr_t  loader word address.
- ld_data  in  inst_t  loader write data.
- ld_ready  out  1  write accepted this cycle (transfer on ld_valid & ld_ready).
- ld_done  in  1  single-cycle pulse: loader finished, enter RUN.
- ld_start  in  1  single-cycle pulse: re-enter LOAD from RUN.
- load_busy  out  1  state == LOAD.
- imaddr  out  im_addr_t  to `im`.
- imwe  out  1  to `im`.
- imdin  out  inst_t  to `im`.
- imce  out  1  to `im`.

## Operation
- State register: LOAD, RUN. Starvation counter `starve_cnt`, $clog2(STARVE_MAX+1) bits. `if_rvalid` is registered. All IM-side outputs are combinational from inputs and registered state.
- LOAD:
  - ld_ready = 1 and if_stall = 1 unconditionally; fetch is ignored.
  - ld_valid: imce=1, imwe=1, imaddr=ld_addr, imdin=ld_data. Otherwise imce=0.
  - ld_done → RUN next cycle. A write presented with ld_done in the same cycle is still accepted.
- RUN, normal cycle (starve_cnt < STARVE_MAX):
  - if_req: imce=1, imwe=0, imaddr=if_addr, if_stall=0, ld_ready=0.
  - !if_req & ld_valid: write is granted, ld_ready=1.
  - Neither: imce=0.
- RUN, forced cycle (starve_cnt == STARVE_MAX & ld_valid): loader is granted, ld_ready=1. if_stall = if_req; no read is issued.
- starve_cnt:
  - Increments in RUN when ld_valid & !ld_ready.
  - Clears on any loader grant, when ld_valid is low, and on every LOAD cycle.
  - Saturates at STARVE_MAX.
- ld_start in RUN → LOAD next cycle. ld_done in RUN and ld_start in LOAD are ignored.
- During reset (cpu_rst_n low): imce=1, imwe=0, imaddr=0, imdin=0. This keeps `im`'s synchronous inst clear enabled.
- Width rules: addresses pass through unmodified; no truncation or wrap is performed by this block.

## Timing
- Reset values: state=LOAD, starve_cnt=0, if_rvalid=0, if_stall=1, ld_ready=0 (until reset deasserts), load_busy=1.
- Read latency 1: a fetch served in cycle N gives `inst` valid with if_rvalid=1 in cycle N+1.
- Write takes effect at the end of cycle N. A fetch of the same address in N+1 returns the new data in N+2.
- Back-to-back: one access per cycle, with 100 % fetch throughput in RUN except on forced cycles.
- A read served in the last RUN cycle before LOAD still produces if_rvalid in the following cycle.
- Asynchronous reset mid-operation:
  - State returns to LOAD immediately and starve_cnt clears.
  - if_rvalid drops immediately; the in-flight read is discarded.
  - A write in the reset cycle is not performed (imwe=0).

## Configuration
- IM_LOADER_EN defined: behaviour as above.
- IM_LOADER_EN undefined:
  - State is fixed at RUN; reset value load_busy=0 and if_stall=0.
  - ld_ready tied 0; ld_* inputs, ld_done and ld_start are ignored.
  - Starvation counter is removed.
  - IM contents come only from the BRAM initial image.

## Test plan
- Boot load: after reset, write 0x3401_0064 to addr 1 and 0x3C02_6500 to addr 2, then pulse ld_done. Required: load_busy falls next cycle; fetch of addr 1 then addr 2 returns those words with if_rvalid=1 one cycle after each request.
- Fetch priority: in RUN, hold if_req=1 and ld_valid=1. Required: ld_ready=0 for exactly 15 cycles. In cycle 16, ld_ready=1 and if_stall=1. Next cycle, fetch resumes with if_stall=0.
- Idle slot: in RUN, drop if_req for one cycle while ld_valid=1 at addr 5 with data 0x2423_0004. Required: ld_ready=1 that cycle and starve_cnt=0. A fetch of addr 5 one cycle later returns 0x2423_0004.
- Simultaneous ld_done and ld_valid in LOAD. Required: the write is performed and the state is RUN next cycle.
- Reset mid-fetch: assert cpu_rst_n low in the cycle after a fetch is served. Required: if_rvalid=0 immediately, load_busy=1, imce=1/imwe=0, and `inst` reads 0 after the next edge.
- With IM_LOADER_EN undefined: after reset, if_stall=0 and fetch of addr 1 returns the initial image word. ld_valid=1 never raises ld_ready.
